// File: rtl/pulse_transmitter_pkg.sv
// Shared types for the pulse transmitter sequencer: FSM states, interrupt modes,
// widths and small helpers used by the sequencer datapath.
package pulse_transmitter_pkg;

    localparam int PC_W    = 7;
    localparam int DUR_W   = 8;
    localparam int NUM_SYM = 4;
    localparam int WRAP_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] INT_OFF  = 2'b00;
    localparam logic [1:0] INT_DONE = 2'b01;
    localparam logic [1:0] INT_WRAP = 2'b10;
    localparam logic [1:0] INT_BOTH = 2'b11;

    // Symbol code selects one byte-wide duration out of the packed table.
    function automatic logic [DUR_W-1:0] dur_lookup(
        input logic [NUM_SYM*DUR_W-1:0] tbl,
        input logic [1:0]               sym
    );
        return tbl[int'(sym)*DUR_W +: DUR_W];
    endfunction

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        return (v == {WRAP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pulse_transmitter_rising_edge_detector.sv
// Registered rising-edge detector: rise pulses one cycle after sig is first seen high.
// History only advances while en is high, so edges seen while disabled are dropped.
module pulse_transmitter_rising_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sig,
    output logic rise
);

    logic hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= 1'b0;
            rise <= 1'b0;
        end else if (en) begin
            hist <= sig;
            rise <= sig & ~hist;
        end else begin
            rise <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_transmitter_sequencer.sv
// Walks a symbol program, triggering an external timer per symbol and driving the pulse level.
// Start edge to LOAD is two edges; one LOAD cycle separates each timer expiry from the next trigger.
module pulse_transmitter_sequencer
    import pulse_transmitter_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_start,
    input  logic                       cfg_loop,
    input  logic [1:0]                 cfg_int_mode,
    input  logic [PC_W-1:0]            cfg_prog_start,
    input  logic [PC_W-1:0]            cfg_prog_end,
    input  logic [NUM_SYM*DUR_W-1:0]   cfg_dur_table,
    output logic [PC_W-1:0]            sym_addr,
    input  logic [1:0]                 sym_data,
    output logic                       tim_trig,
    output logic [DUR_W-1:0]           tim_duration,
    input  logic                       tim_done,
    output logic                       level_out,
    output logic                       busy,
    output logic                       done_pulse,
    output logic [WRAP_W-1:0]          wrap_count,
    output logic                       irq,
    input  logic                       irq_clr
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            start_en;
    logic            start_rise;
    logic            at_end;
    logic            wrap_evt;
    logic            comp_evt;
    logic            irq_set;

    assign start_en = (state == ST_IDLE);

    pulse_transmitter_rising_edge_detector u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (start_en),
        .sig   (cfg_start),
        .rise  (start_rise)
    );

    assign sym_addr     = pc;
    assign busy         = (state != ST_IDLE);
    assign tim_trig     = rst_n && (state == ST_LOAD);
    assign tim_duration = tim_trig ? dur_lookup(cfg_dur_table, sym_data) : '0;
    assign at_end       = (pc == cfg_prog_end);

    // Events are suppressed when the program is being aborted in the same cycle.
    assign comp_evt   = rst_n && cfg_start && (state == ST_DONE);
    assign wrap_evt   = rst_n && cfg_start && (state == ST_RUN) && tim_done && at_end && cfg_loop;
    assign done_pulse = comp_evt;

    always_comb begin
        irq_set = 1'b0;
        case (cfg_int_mode)
            INT_OFF:  irq_set = 1'b0;
            INT_DONE: irq_set = comp_evt;
            INT_WRAP: irq_set = wrap_evt;
            INT_BOTH: irq_set = comp_evt | wrap_evt;
            default:  irq_set = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            level_out  <= 1'b0;
            wrap_count <= '0;
            irq        <= 1'b0;
        end else begin
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end

            if (!cfg_start) begin
                state     <= ST_IDLE;
                level_out <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_rise) begin
                            pc         <= cfg_prog_start;
                            wrap_count <= '0;
                            state      <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        level_out <= sym_data[1];
                        state     <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (tim_done) begin
                            if (!at_end) begin
                                pc    <= pc + 1'b1;
                                state <= ST_LOAD;
                            end else if (cfg_loop) begin
                                pc         <= cfg_prog_start;
                                wrap_count <= sat_inc(wrap_count);
                                state      <= ST_LOAD;
                            end else begin
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        level_out <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Scoreboard bench: expected timer triggers and completions are queued by the stimulus
// process and popped by a negedge monitor; a behavioural timer answers each trigger.
module tb_pulse_transmitter_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_loop;
    logic [1:0]  cfg_int_mode;
    logic [6:0]  cfg_prog_start;
    logic [6:0]  cfg_prog_end;
    logic [31:0] cfg_dur_table;
    logic [6:0]  sym_addr;
    logic [1:0]  sym_data;
    logic        tim_trig;
    logic [7:0]  tim_duration;
    logic        tim_done = 1'b0;
    logic        level_out;
    logic        busy;
    logic        done_pulse;
    logic [7:0]  wrap_count;
    logic        irq;
    logic        irq_clr;

    logic [1:0]  mem [0:127];
    assign sym_data = mem[sym_addr];

    always #5 clk = ~clk;

    pulse_transmitter_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_loop       (cfg_loop),
        .cfg_int_mode   (cfg_int_mode),
        .cfg_prog_start (cfg_prog_start),
        .cfg_prog_end   (cfg_prog_end),
        .cfg_dur_table  (cfg_dur_table),
        .sym_addr       (sym_addr),
        .sym_data       (sym_data),
        .tim_trig       (tim_trig),
        .tim_duration   (tim_duration),
        .tim_done       (tim_done),
        .level_out      (level_out),
        .busy           (busy),
        .done_pulse     (done_pulse),
        .wrap_count     (wrap_count),
        .irq            (irq),
        .irq_clr        (irq_clr)
    );

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] dur;
        logic       lvl;
    } trig_exp_t;

    trig_exp_t trig_q[$];
    int        done_q[$];
    int        checks = 0;
    int        errors = 0;
    int        trig_seen = 0;
    int        done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timer: tim_done is high for one cycle, dur+1 cycles after the trigger cycle.
    int tcnt = 0;
    always @(negedge clk) begin
        tim_done = 1'b0;
        if (tcnt > 0) begin
            tcnt--;
            if (tcnt == 0) tim_done = 1'b1;
        end
        if (tim_trig) tcnt = int'(tim_duration) + 1;
    end

    trig_exp_t mon_e;
    logic      lvl_pend = 1'b0;
    logic      lvl_exp  = 1'b0;
    always @(negedge clk) begin
        if (lvl_pend) begin
            check("level_after_load", level_out, lvl_exp);
            lvl_pend = 1'b0;
        end
        if (tim_trig) begin
            trig_seen++;
            if (trig_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_trig: sym_addr=%0d dur=%0h, none expected at %0t",
                         sym_addr, tim_duration, $time);
            end else begin
                mon_e = trig_q.pop_front();
                check("trig_sym_addr", sym_addr, mon_e.addr);
                check("trig_duration", tim_duration, mon_e.dur);
                lvl_exp  = mon_e.lvl;
                lvl_pend = 1'b1;
            end
        end else begin
            check("duration_idle_zero", tim_duration, 8'h00);
        end
        if (done_pulse) begin
            done_seen++;
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done_pulse=1, none expected at %0t", $time);
            end else begin
                void'(done_q.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cfg_basic(input logic [1:0] mode);
        cfg_prog_start = 7'd2;
        cfg_prog_end   = 7'd4;
        cfg_loop       = 1'b0;
        cfg_int_mode   = mode;
        mem[2] = 2'd2;
        mem[3] = 2'd0;
        mem[4] = 2'd3;
    endtask

    task automatic push_basic();
        trig_q.push_back('{addr: 7'd2, dur: 8'h05, lvl: 1'b1});
        trig_q.push_back('{addr: 7'd3, dur: 8'h02, lvl: 1'b0});
        trig_q.push_back('{addr: 7'd4, dur: 8'h0A, lvl: 1'b1});
        done_q.push_back(1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int n;
        d0 = done_seen;
        n  = 0;
        while (done_seen == d0 && n < budget) begin
            step();
            n++;
        end
        check(name, done_seen - d0, 1);
    endtask

    task automatic cfg_loop3();
        cfg_prog_start = 7'd3;
        cfg_prog_end   = 7'd3;
        cfg_loop       = 1'b1;
        cfg_int_mode   = 2'b10;
        mem[3] = 2'd0;
        for (int i = 0; i < 300; i++) trig_q.push_back('{addr: 7'd3, dur: 8'h02, lvl: 1'b0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        for (int i = 0; i < 128; i++) mem[i] = 2'd0;
        rst_n          = 1'b0;
        cfg_start      = 1'b0;
        cfg_loop       = 1'b0;
        cfg_int_mode   = 2'b00;
        cfg_prog_start = 7'd0;
        cfg_prog_end   = 7'd0;
        cfg_dur_table  = 32'h0A05_0302;
        irq_clr        = 1'b0;
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_level", level_out, 0);
        check("rst_wrap", wrap_count, 0);
        check("rst_irq", irq, 0);
        check("rst_sym_addr", sym_addr, 0);
        check("rst_trig", tim_trig, 0);
        check("rst_done", done_pulse, 0);
        check("rst_duration", tim_duration, 0);
        rst_n = 1'b1;
        step();

        // Basic three-symbol program, completion interrupt, start latency.
        cfg_basic(2'b01);
        push_basic();
        cfg_start = 1'b1;
        step();
        check("latency_still_idle", busy, 0);
        step();
        check("latency_load_busy", busy, 1);
        check("latency_load_trig", tim_trig, 1);
        wait_done("basic_done", 100);
        step();
        check("basic_idle", busy, 0);
        check("basic_level_low", level_out, 0);
        check("basic_irq", irq, 1);
        check("basic_trig_q_empty", trig_q.size(), 0);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        check("irq_cleared", irq, 0);
        cfg_start = 1'b0;
        step();

        // Program wrapping through address 127 -> 0, interrupts off.
        cfg_prog_start = 7'd126;
        cfg_prog_end   = 7'd1;
        cfg_int_mode   = 2'b00;
        mem[126] = 2'd1;
        mem[127] = 2'd2;
        mem[0]   = 2'd0;
        mem[1]   = 2'd3;
        trig_q.push_back('{addr: 7'd126, dur: 8'h03, lvl: 1'b0});
        trig_q.push_back('{addr: 7'd127, dur: 8'h05, lvl: 1'b1});
        trig_q.push_back('{addr: 7'd0,   dur: 8'h02, lvl: 1'b0});
        trig_q.push_back('{addr: 7'd1,   dur: 8'h0A, lvl: 1'b1});
        done_q.push_back(1);
        cfg_start = 1'b1;
        wait_done("addr_wrap_done", 100);
        step();
        check("addr_wrap_idle", busy, 0);
        check("addr_wrap_irq_off", irq, 0);
        check("addr_wrap_trig_q_empty", trig_q.size(), 0);
        cfg_start = 1'b0;
        step();

        // One-symbol looping program: wrap interrupt and saturating wrap count.
        cfg_loop3();
        base = trig_seen;
        cfg_start = 1'b1;
        n = 0;
        while (trig_seen == base && n < 20) begin step(); n++; end
        check("loop_first_trig", trig_seen - base, 1);
        check("loop_irq_before_wrap", irq, 0);
        check("loop_wrap_before", wrap_count, 0);
        n = 0;
        while (wrap_count != 8'd1 && n < 20) begin step(); n++; end
        check("loop_first_wrap", wrap_count, 1);
        check("loop_irq_after_wrap", irq, 1);
        n = 0;
        while (trig_seen < base + 260 && n < 2000) begin step(); n++; end
        check("loop_trig_count", trig_seen - base, 260);
        check("loop_wrap_saturated", wrap_count, 255);
        check("loop_still_busy", busy, 1);
        cfg_start = 1'b0;
        step();
        check("loop_abort_idle", busy, 0);
        check("loop_abort_level", level_out, 0);
        check("loop_abort_wrap_held", wrap_count, 255);
        trig_q.delete();
        repeat (20) step();
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;

        // Abort in the same cycle as a timer expiry.
        cfg_basic(2'b01);
        trig_q.push_back('{addr: 7'd2, dur: 8'h05, lvl: 1'b1});
        base = done_seen;
        cfg_start = 1'b1;
        n = 0;
        while (tim_done !== 1'b1 && n < 30) begin step(); n++; end
        check("abort_saw_tim_done", tim_done, 1);
        check("abort_level_high", level_out, 1);
        cfg_start = 1'b0;
        step();
        check("abort_idle", busy, 0);
        check("abort_level_low", level_out, 0);
        check("abort_irq_unchanged", irq, 0);
        repeat (10) step();
        check("abort_no_done", done_seen - base, 0);
        check("abort_trig_q_empty", trig_q.size(), 0);
        repeat (10) step();

        // Reset mid-run, then a fresh start edge.
        cfg_loop3();
        cfg_start = 1'b1;
        n = 0;
        while (wrap_count != 8'd2 && n < 40) begin step(); n++; end
        check("prereset_wrap", wrap_count, 2);
        step();
        step();
        check("prereset_irq", irq, 1);
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_level", level_out, 0);
        check("midrst_sym_addr", sym_addr, 0);
        check("midrst_wrap", wrap_count, 0);
        check("midrst_irq", irq, 0);
        check("midrst_trig", tim_trig, 0);
        check("midrst_done", done_pulse, 0);
        trig_q.delete();
        repeat (20) step();
        cfg_dur_table = 32'h0A05_0302;
        cfg_basic(2'b01);
        push_basic();
        cfg_start = 1'b1;
        wait_done("restart_done", 100);
        step();
        check("restart_irq", irq, 1);
        check("restart_wrap", wrap_count, 0);
        check("restart_trig_q_empty", trig_q.size(), 0);
        check("restart_done_q_empty", done_q.size(), 0);
        cfg_start = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
